// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction/operand fetch unit with memory timeout
// Loads IR or OPR from memory at MAR, advances PC, and handles jump/halt commands.
module fetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] state,
  input  logic [3:0] cycle,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  output logic [7:0] instruction,
  output logic [7:0] operand,
  output logic [7:0] pc,
  output logic       stall,
  output logic       halted,
  output logic       bus_err
);

  localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
  localparam logic [7:0] STATE_FETCH_INST = 8'h02;
  localparam logic [7:0] STATE_JUMP       = 8'h03;
  localparam logic [7:0] STATE_HALT       = 8'h04;
  localparam logic [3:0] T2               = 4'd2;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} fsm_t;

  fsm_t          fsm;
  logic [7:0]    prev_state;
  logic [CW-1:0] wait_cnt;
  logic          target_ir;
  logic          fetch_start;

  // Edge-detect on FETCH_INST so a held command issues a single fetch.
  assign fetch_start = (fsm == IDLE) && (state == STATE_FETCH_INST) &&
                       (prev_state != STATE_FETCH_INST) && !halted;
  assign stall = !reset && ((fsm == WAIT) || fetch_start);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      prev_state  <= 8'h00;
      wait_cnt    <= '0;
      target_ir   <= 1'b0;
      mem_addr    <= 8'h00;
      mem_req     <= 1'b0;
      instruction <= 8'h00;
      operand     <= 8'h00;
      pc          <= 8'h00;
      halted      <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      prev_state <= state;
      case (fsm)
        IDLE: begin
          if (fetch_start) begin
            target_ir <= (cycle == T2);
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            fsm       <= WAIT;
          end else if (!halted) begin
            case (state)
              STATE_FETCH_PC: mem_addr <= pc;
              STATE_JUMP:     pc       <= operand;
              STATE_HALT:     halted   <= 1'b1;
              default: ;
            endcase
          end
        end
        WAIT: begin
          // An ack on the final wait cycle wins over the timeout.
          if (mem_ack) begin
            if (target_ir) instruction <= mem_rdata;
            else           operand     <= mem_rdata;
            pc      <= pc + 8'd1;
            mem_req <= 1'b0;
            fsm     <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            if (target_ir) instruction <= 8'h00;
            else           operand     <= 8'h00;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            fsm     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Randomized fetches compared against a transaction-level model of PC/IR/OPR/flags.
module tb_fetch_unit;

  localparam logic [7:0] S_IDLE  = 8'h00;
  localparam logic [7:0] S_FPC   = 8'h01;
  localparam logic [7:0] S_FINST = 8'h02;
  localparam logic [7:0] S_JUMP  = 8'h03;
  localparam logic [7:0] S_HALT  = 8'h04;
  localparam logic [3:0] T1 = 4'd1;
  localparam logic [3:0] T2 = 4'd2;
  localparam logic [3:0] T3 = 4'd3;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] state;
  logic [3:0] cycle;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] instruction;
  logic [7:0] operand;
  logic [7:0] pc;
  logic       stall;
  logic       halted;
  logic       bus_err;

  always #5 clk = ~clk;

  fetch_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .state(state), .cycle(cycle),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_req(mem_req), .instruction(instruction), .operand(operand),
    .pc(pc), .stall(stall), .halted(halted), .bus_err(bus_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_pc, m_ir, m_opr, m_mar;
  logic       m_halted, m_bus_err;

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_opr = 8'h00; m_mar = 8'h00;
    m_halted = 1'b0; m_bus_err = 1'b0;
  endtask

  // One FETCH_PC + FETCH_INST transaction; delay = WAIT cycle carrying the ack, 0 = never.
  task automatic fetch(input logic [3:0] cyc, input logic [7:0] data, input int delay,
                       input int hold, input string tag);
    int stalls = 0;
    int reqs = 0;
    int extra = 0;
    bit done = 0;
    @(posedge clk); #1;
    state = S_FPC; cycle = T1;
    @(posedge clk); #1;
    state = S_FINST; cycle = cyc;
    if (!m_halted) m_mar = m_pc;
    @(negedge clk);
    checks++;
    if (mem_addr !== m_mar) begin
      errors++; $display("FAIL %s mar: got %02h want %02h", tag, mem_addr, m_mar);
    end
    if (stall) stalls++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == delay);
      mem_rdata = (k == delay) ? data : 8'($urandom);
      @(negedge clk);
      if (mem_req) reqs++;
      if (!stall) begin done = 1; break; end
      stalls++;
      checks++;
      if (mem_addr !== m_mar) begin
        errors++; $display("FAIL %s mar_hold: got %02h want %02h", tag, mem_addr, m_mar);
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s stall_stuck: got 1 want 0 within 40 cycles", tag);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mem_req) extra++;
    end
    @(posedge clk); #1;
    state = S_IDLE;
    if (!m_halted) begin
      if (delay >= 1 && delay <= TMO) begin
        if (cyc == T2) m_ir = data; else m_opr = data;
        m_pc = m_pc + 8'd1;
      end else begin
        if (cyc == T2) m_ir = 8'h00; else m_opr = 8'h00;
        m_bus_err = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (stalls != (m_halted ? 0 : ((delay >= 1 && delay <= TMO) ? delay + 1 : TMO + 1))) begin
      errors++; $display("FAIL %s stall_cycles: got %0d delay %0d halted %0b", tag, stalls, delay, m_halted);
    end
    checks++;
    if (reqs != (m_halted ? 0 : ((delay >= 1 && delay <= TMO) ? delay : TMO))) begin
      errors++; $display("FAIL %s req_cycles: got %0d delay %0d halted %0b", tag, reqs, delay, m_halted);
    end
    checks++;
    if (extra != 0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s req_after: got %0d extra, req %0b want 0", tag, extra, mem_req);
    end
    checks++;
    if (instruction !== m_ir || operand !== m_opr || pc !== m_pc) begin
      errors++; $display("FAIL %s regs: got ir %02h opr %02h pc %02h want %02h %02h %02h",
                         tag, instruction, operand, pc, m_ir, m_opr, m_pc);
    end
    checks++;
    if (bus_err !== m_bus_err || halted !== m_halted) begin
      errors++; $display("FAIL %s flags: got err %0b halt %0b want %0b %0b",
                         tag, bus_err, halted, m_bus_err, m_halted);
    end
  endtask

  task automatic jump(input string tag);
    @(posedge clk); #1;
    state = S_JUMP;
    @(posedge clk); #1;
    state = S_IDLE;
    if (!m_halted) m_pc = m_opr;
    @(negedge clk);
    checks++;
    if (pc !== m_pc) begin
      errors++; $display("FAIL %s jump_pc: got %02h want %02h", tag, pc, m_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; state = S_FINST; cycle = T2; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %0b want 0", stall);
    end
    #1; reset = 1'b0; state = S_IDLE;
    model_reset();
    checks++;
    if ({mem_addr, instruction, operand, pc} !== 32'h0 || {mem_req, halted, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_vals: got mar %02h ir %02h opr %02h pc %02h req %0b halt %0b err %0b want all 0",
                         mem_addr, instruction, operand, pc, mem_req, halted, bus_err);
    end
  endtask

  task automatic test_basic_fetch();
    fetch(T2, 8'h5A, 2, 0, "basic");
  endtask

  task automatic test_operand_jump();
    fetch(T3, 8'h40, $urandom_range(1, 4), 0, "operand");
    jump("operand");
  endtask

  task automatic test_wrap();
    fetch(T3, 8'hFF, 1, 0, "wrap_opr");
    jump("wrap");
    fetch(T2, 8'h12, 3, 0, "wrap");
  endtask

  task automatic test_timeout();
    fetch(T2, 8'h77, 0, 0, "timeout");
    fetch(T2, 8'h33, 2, 0, "after_timeout");
  endtask

  task automatic test_ack_on_last_cycle();
    fetch(T3, 8'hC3, TMO, 0, "ack_last");
  endtask

  task automatic test_held_command();
    fetch(T2, 8'h9E, 1, 8, "held");
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 8'($urandom);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (instruction !== m_ir || operand !== m_opr || pc !== m_pc || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_ack: got ir %02h opr %02h pc %02h req %0b want %02h %02h %02h 0",
                         instruction, operand, pc, mem_req, m_ir, m_opr, m_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) jump("rnd");
      else fetch($urandom_range(0, 1) ? T2 : T3, 8'($urandom), (r == 1) ? 0 : $urandom_range(1, 6), 0, "rnd");
    end
  endtask

  task automatic test_halt();
    @(posedge clk); #1;
    state = S_HALT;
    @(posedge clk); #1;
    state = S_IDLE;
    m_halted = 1'b1;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL halt_flag: got %0b want 1", halted);
    end
    fetch(T2, 8'hEE, 2, 0, "halted");
    jump("halted");
  endtask

  task automatic test_reset_wait();
    @(posedge clk); #1;
    state = S_FPC; cycle = T1;
    @(posedge clk); #1;
    state = S_FINST; cycle = T2;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hA5;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0; state = S_IDLE;
    model_reset();
    @(negedge clk);
    checks++;
    if ({mem_addr, instruction, operand, pc} !== 32'h0 ||
        {mem_req, stall, halted, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_wait: got mar %02h ir %02h opr %02h pc %02h req %0b stall %0b halt %0b err %0b want all 0",
                         mem_addr, instruction, operand, pc, mem_req, stall, halted, bus_err);
    end
    fetch(T2, 8'h21, 2, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_operand_jump();
    test_wrap();
    test_timeout();
    test_ack_on_last_cycle();
    test_held_command();
    test_idle_ack();
    test_random();
    test_halt();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
